gpio_bank: RTL and testbench
============================

# gpio_bank

Parametrised GPIO controller and successor to the fixed 10-bit GPIO block. It adds per-pin direction control, atomic set/clear writes, synchronised input sampling and per-pin rising/falling edge interrupts with write-1-to-clear status. It sits on the SoC data-memory bus beside the other memory-mapped peripherals and uses the same separate read/write address ports and word-indexed register offsets from `BASE_ADDR`.

## Interface
Parameters:
- `WIDTH`, default 10: number of pins, 1..32.
- `BASE_ADDR`, default 32'ha000_0000: address of register offset 0; register n is at `BASE_ADDR`+n.
- `SYNC_STAGES`, default 2: flop stages on `gpio_in`, minimum 2.

Ports:
- `clk`  in  1  system clock; the block uses this single clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `gpio_read_address`  in  32  read address.
- `gpio_read_data`  out  32  registered read data.
- `gpio_write_address`  in  32  write address.
- `gpio_write_data`  in  32  write data.
- `gpio_write_enable`  in  1  write strobe, one access per cycle.
- `gpio_in`  in  WIDTH  asynchronous pad inputs.
- `gpio_out`  out  WIDTH  pad output values.
- `gpio_oe`  out  WIDTH  pad output enables; 1 drives the pin.
- `gpio_irq`  out  1  level interrupt to the core.

## Operation
Register map by offset. Only bits [WIDTH-1:0] are implemented; upper bits read 0.
- 0 CTRL (R/W): bit0 is the global interrupt enable. Other bits read 0.
- 1 OUT (R/W): output data register.
- 2 DIR (R/W): 1 = output.
- 3 IN (RO): synchronised pin value. Writes are ignored.
- 4 OUT_SET (WO): OUT |= wdata. Reads 0.
- 5 OUT_CLR (WO): OUT &= ~wdata. Reads 0.
- 6 RISE_EN (R/W): per-pin rising-edge interrupt enable.
- 7 FALL_EN (R/W): per-pin falling-edge interrupt enable.
- 8 IRQ_STATUS (R/W1C): sticky per-pin edge flags.

Output and interrupt behaviour:
- `gpio_out` = OUT and `gpio_oe` = DIR, both driven directly from the registers.
- IN samples `gpio_in` for every pin regardless of DIR, so output pins read back their own pad value.
- Edge detection: `prev` holds the last synchronised value. rise = sync & ~prev; fall = ~sync & prev.
- Status update each cycle: STATUS[i] is set when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- Enable bits gate only the *setting* of flags. Clearing RISE_EN/FALL_EN does not clear existing flags.
- `gpio_irq` = CTRL[0] & |IRQ_STATUS. It is driven from registered state and has no combinational path from the bus.
- Unmapped addresses inside or outside the block: writes are ignored and reads return 0.

## Timing
- Reset (`reset_n` low, takes effect asynchronously): all registers, the synchroniser and `prev` go to 0. Resulting outputs:
  - `gpio_out` = 0, `gpio_oe` = 0 (all pins inputs).
  - `gpio_irq` = 0, `gpio_read_data` = 0.
  - No edge is detected on the first cycle after reset release if the pin is already 0. A pin held high through reset release produces a rising edge SYNC_STAGES+1 cycles later. This is acceptable because RISE_EN is 0 after reset.
- Writes: register updates on the `clk` edge where `gpio_write_enable` is high. `gpio_out`/`gpio_oe` change in that same cycle.
- Reads: `gpio_read_data` is valid one cycle after the address is presented, with no enable. It reflects register state before any write issued in that same cycle.
- Pin change to IN: visible in the register after SYNC_STAGES edges, and readable on `gpio_read_data` one cycle later.
- Pin edge to STATUS set: SYNC_STAGES+1 edges. `gpio_irq` asserts in the same cycle STATUS is set.
- W1C of IRQ_STATUS in the same cycle as a new qualifying edge on the same bit: the set wins and the bit stays 1.
- A single-cycle pulse shorter than one clock may be missed. Pulses of at least one period are guaranteed to be captured.

## Structure
- Shared package `gpio_pkg`:
  - register offset constants `GPIO_OFS_CTRL` .. `GPIO_OFS_IRQ_STATUS` (0..8);
  - CTRL bit index `GPIO_CTRL_IRQ_EN` = 0.
- Sub-module `gpio_sync`: WIDTH-wide, SYNC_STAGES-deep flop chain with async active-low reset to 0. It is instantiated once for `gpio_in`.
- Address decode is `gpio_write_address - BASE_ADDR` with an in-range check against offsets 0..8.

## Test plan
- Reset values: assert `reset_n` mid-operation with OUT=0x3FF and DIR=0x3FF. Outputs, `gpio_irq` and `gpio_read_data` must go to 0 immediately, without a clock edge.
- Set/clear: write OUT=0x0F0, OUT_SET 0x00F, then OUT_CLR 0x0C0. `gpio_out` must read 0x0F0, then 0x0FF, then 0x03F. Reads of offsets 4 and 5 must return 0.
- Synchronisation: drive `gpio_in`=0x155 and read IN continuously. The read shows 0x155 exactly SYNC_STAGES+1 cycles after the change.
- Rising interrupt: set RISE_EN=0x001 and CTRL=1, then raise pin 0. STATUS=0x001 and `gpio_irq`=1 after SYNC_STAGES+1 edges. The falling edge of pin 0 does not set a flag. Write 0x001 to offset 8 and `gpio_irq` drops the next cycle.
- Set/clear collision: with FALL_EN=0x002, time a W1C of STATUS bit 1 onto the cycle where a pin 1 falling edge is detected. The bit must remain 1.
- Address decode: with WIDTH=4 and BASE_ADDR=0x1000, write 0xFFFF_FFFF to OUT. It reads 0x0000_000F. A write to 0x1009 changes nothing, and a read of 0x1009 returns 0.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the GPIO bank.
//   gpio_ofs_e        word offsets of the registers relative to BASE_ADDR
//   GPIO_NUM_REGS     number of mapped offsets (0..GPIO_NUM_REGS-1)
//   GPIO_CTRL_IRQ_EN  CTRL bit holding the global interrupt enable
package gpio_pkg;

    typedef enum logic [3:0] {
        GPIO_OFS_CTRL       = 4'd0,
        GPIO_OFS_OUT        = 4'd1,
        GPIO_OFS_DIR        = 4'd2,
        GPIO_OFS_IN         = 4'd3,
        GPIO_OFS_OUT_SET    = 4'd4,
        GPIO_OFS_OUT_CLR    = 4'd5,
        GPIO_OFS_RISE_EN    = 4'd6,
        GPIO_OFS_FALL_EN    = 4'd7,
        GPIO_OFS_IRQ_STATUS = 4'd8
    } gpio_ofs_e;

    localparam int unsigned GPIO_NUM_REGS    = 9;
    localparam int unsigned GPIO_CTRL_IRQ_EN = 0;

    // True when addr falls on one of the mapped word offsets above base.
    // The subtraction wraps, so addresses below base land far out of range.
    function automatic logic gpio_addr_hit(input logic [31:0] addr,
                                           input logic [31:0] base);
        logic [31:0] diff;
        diff = addr - base;
        return diff < 32'(GPIO_NUM_REGS);
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: STAGES-deep flop chain bringing asynchronous pad inputs into
// the clk domain.
//   clk      system clock
//   reset_n  asynchronous active-low reset, clears every stage to 0
//   d        asynchronous input bits (WIDTH)
//   q        synchronised output, last stage of the chain (WIDTH)
module gpio_sync #(
    parameter int unsigned WIDTH  = 10,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: memory-mapped GPIO controller with per-pin direction, atomic
// set/clear of the output register, synchronised input sampling and per-pin
// rising/falling edge interrupts with write-1-to-clear status.
//   clk                 system clock
//   reset_n             asynchronous active-low reset
//   gpio_read_address   read address (word offsets from BASE_ADDR)
//   gpio_read_data      registered read data, valid one cycle after address
//   gpio_write_address  write address
//   gpio_write_data     write data
//   gpio_write_enable   write strobe
//   gpio_in             asynchronous pad inputs (WIDTH)
//   gpio_out            pad output values (WIDTH)
//   gpio_oe             pad output enables, 1 drives the pin (WIDTH)
//   gpio_irq            level interrupt
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter logic [31:0] BASE_ADDR   = 32'ha000_0000,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [31:0]      gpio_read_address,
    output logic [31:0]      gpio_read_data,
    input  logic [31:0]      gpio_write_address,
    input  logic [31:0]      gpio_write_data,
    input  logic             gpio_write_enable,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             gpio_irq
);

    logic             ctrl_irq_en;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] rise_en_q;
    logic [WIDTH-1:0] fall_en_q;
    logic [WIDTH-1:0] status_q;
    logic [WIDTH-1:0] status_d;
    logic [WIDTH-1:0] in_sync;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] w1c_mask;
    logic [31:0]      wr_diff;
    logic [31:0]      rd_diff;
    logic             wr_hit;
    gpio_ofs_e        wr_ofs;
    gpio_ofs_e        rd_ofs;
    logic [31:0]      rd_word;
    logic             unused_wdata_bits;

    assign wdata             = gpio_write_data[WIDTH-1:0];
    assign unused_wdata_bits = ^gpio_write_data;

    gpio_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (gpio_in),
        .q       (in_sync)
    );

    assign wr_diff = gpio_write_address - BASE_ADDR;
    assign rd_diff = gpio_read_address - BASE_ADDR;
    assign wr_ofs  = gpio_ofs_e'(wr_diff[3:0]);
    assign rd_ofs  = gpio_ofs_e'(rd_diff[3:0]);
    assign wr_hit  = gpio_write_enable && gpio_addr_hit(gpio_write_address, BASE_ADDR);

    // A new qualifying edge is OR-ed in after the W1C mask, so a set in the
    // same cycle as a clear of the same bit leaves the bit at 1.
    always_comb begin
        edge_set = (in_sync & ~prev_q & rise_en_q) | (~in_sync & prev_q & fall_en_q);
        w1c_mask = '0;
        if (wr_hit && wr_ofs == GPIO_OFS_IRQ_STATUS) begin
            w1c_mask = wdata;
        end
        status_d = (status_q & ~w1c_mask) | edge_set;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_irq_en <= 1'b0;
            out_q       <= '0;
            dir_q       <= '0;
            rise_en_q   <= '0;
            fall_en_q   <= '0;
            status_q    <= '0;
            prev_q      <= '0;
        end else begin
            prev_q   <= in_sync;
            status_q <= status_d;
            if (wr_hit) begin
                case (wr_ofs)
                    GPIO_OFS_CTRL:    ctrl_irq_en <= gpio_write_data[GPIO_CTRL_IRQ_EN];
                    GPIO_OFS_OUT:     out_q       <= wdata;
                    GPIO_OFS_DIR:     dir_q       <= wdata;
                    GPIO_OFS_OUT_SET: out_q       <= out_q | wdata;
                    GPIO_OFS_OUT_CLR: out_q       <= out_q & ~wdata;
                    GPIO_OFS_RISE_EN: rise_en_q   <= wdata;
                    GPIO_OFS_FALL_EN: fall_en_q   <= wdata;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (gpio_addr_hit(gpio_read_address, BASE_ADDR)) begin
            case (rd_ofs)
                GPIO_OFS_CTRL:       rd_word[GPIO_CTRL_IRQ_EN] = ctrl_irq_en;
                GPIO_OFS_OUT:        rd_word = 32'(out_q);
                GPIO_OFS_DIR:        rd_word = 32'(dir_q);
                GPIO_OFS_IN:         rd_word = 32'(in_sync);
                GPIO_OFS_RISE_EN:    rd_word = 32'(rise_en_q);
                GPIO_OFS_FALL_EN:    rd_word = 32'(fall_en_q);
                GPIO_OFS_IRQ_STATUS: rd_word = 32'(status_q);
                default:             rd_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gpio_read_data <= '0;
        end else begin
            gpio_read_data <= rd_word;
        end
    end

    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign gpio_irq = ctrl_irq_en & (|status_q);

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;

    localparam logic [31:0] BASE  = 32'ha000_0000;
    localparam logic [31:0] BASE4 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic [31:0] ra, rdata, wa, wd;
    logic        we;
    logic [9:0]  pins, gout, goe;
    logic        irq;

    logic [31:0] ra4, rdata4, wa4, wd4;
    logic        we4;
    logic [3:0]  pins4, gout4, goe4;
    logic        irq4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    gpio_bank dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .gpio_read_address  (ra),
        .gpio_read_data     (rdata),
        .gpio_write_address (wa),
        .gpio_write_data    (wd),
        .gpio_write_enable  (we),
        .gpio_in            (pins),
        .gpio_out           (gout),
        .gpio_oe            (goe),
        .gpio_irq           (irq)
    );

    gpio_bank #(
        .WIDTH     (4),
        .BASE_ADDR (BASE4)
    ) dut4 (
        .clk                (clk),
        .reset_n            (reset_n),
        .gpio_read_address  (ra4),
        .gpio_read_data     (rdata4),
        .gpio_write_address (wa4),
        .gpio_write_data    (wd4),
        .gpio_write_enable  (we4),
        .gpio_in            (pins4),
        .gpio_out           (gout4),
        .gpio_oe            (goe4),
        .gpio_irq           (irq4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected read result and compare it with the DUT output.
    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, obs, e.exp);
        end
    endtask

    task automatic wr(input bit sel4, input logic [31:0] addr, input logic [31:0] data);
        if (sel4) begin
            wa4 = addr; wd4 = data; we4 = 1'b1;
        end else begin
            wa = addr; wd = data; we = 1'b1;
        end
        tick();
        we = 1'b0;
        we4 = 1'b0;
    endtask

    task automatic rd(input bit sel4, input string tag, input logic [31:0] addr,
                      input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
        if (sel4) ra4 = addr; else ra = addr;
        tick();
        pop_chk(sel4 ? rdata4 : rdata);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        ra = BASE; wa = BASE; wd = '0; we = 1'b0; pins = '0;
        ra4 = BASE4; wa4 = BASE4; wd4 = '0; we4 = 1'b0; pins4 = '0;

        // Reset state
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        chk("rst_out", 32'(gout), 32'h0);
        chk("rst_oe", 32'(goe), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rdata", rdata, 32'h0);

        // Set / clear
        wr(0, BASE + 1, 32'h0F0);
        chk("out_write", 32'(gout), 32'h0F0);
        wr(0, BASE + 4, 32'h00F);
        chk("out_set", 32'(gout), 32'h0FF);
        wr(0, BASE + 5, 32'h0C0);
        chk("out_clr", 32'(gout), 32'h03F);
        rd(0, "rd_out", BASE + 1, 32'h03F);
        rd(0, "rd_set_zero", BASE + 4, 32'h0);
        rd(0, "rd_clr_zero", BASE + 5, 32'h0);
        wr(0, BASE + 2, 32'h155);
        chk("oe_dir", 32'(goe), 32'h155);
        rd(0, "rd_dir", BASE + 2, 32'h155);

        // Synchronisation latency: visible on read data after SYNC_STAGES+1 edges
        ra = BASE + 3;
        tick();
        pins = 10'h155;
        for (int k = 1; k <= 4; k++) begin
            e.tag = $sformatf("sync_lat_%0d", k);
            e.exp = (k >= 3) ? 32'h155 : 32'h0;
            exp_q.push_back(e);
            tick();
            pop_chk(rdata);
        end
        wr(0, BASE + 3, 32'h3FF);
        rd(0, "in_write_ignored", BASE + 3, 32'h155);
        pins = '0;
        repeat (4) tick();

        // Rising-edge interrupt on pin 0
        wr(0, BASE + 6, 32'h001);
        wr(0, BASE + 0, 32'h1);
        rd(0, "rd_ctrl", BASE + 0, 32'h1);
        chk("irq_idle", 32'(irq), 32'h0);
        pins[0] = 1'b1;
        tick();
        chk("irq_edge1", 32'(irq), 32'h0);
        tick();
        chk("irq_edge2", 32'(irq), 32'h0);
        tick();
        chk("irq_edge3", 32'(irq), 32'h1);
        rd(0, "status_rise", BASE + 8, 32'h001);
        pins[0] = 1'b0;
        repeat (4) tick();
        rd(0, "status_no_fall", BASE + 8, 32'h001);
        wr(0, BASE + 8, 32'h001);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd(0, "status_cleared", BASE + 8, 32'h0);

        // Clearing the enable keeps an existing flag
        pins[0] = 1'b1;
        repeat (4) tick();
        wr(0, BASE + 6, 32'h0);
        rd(0, "flag_kept", BASE + 8, 32'h001);
        wr(0, BASE + 8, 32'h001);

        // W1C colliding with a new falling edge on pin 1
        wr(0, BASE + 7, 32'h002);
        pins[1] = 1'b1;
        repeat (4) tick();
        rd(0, "no_rise_pin1", BASE + 8, 32'h0);
        pins[1] = 1'b0;
        tick();
        tick();
        wr(0, BASE + 8, 32'h002);
        chk("collision_irq", 32'(irq), 32'h1);
        rd(0, "collision_status", BASE + 8, 32'h002);
        wr(0, BASE + 8, 32'h002);
        rd(0, "status_clear2", BASE + 8, 32'h0);

        // Unmapped addresses
        wr(0, BASE + 9, 32'hFFFF_FFFF);
        chk("unmapped_out", 32'(gout), 32'h03F);
        chk("unmapped_oe", 32'(goe), 32'h155);
        rd(0, "rd_unmapped", BASE + 9, 32'h0);
        rd(0, "rd_below_base", BASE - 1, 32'h0);

        // Narrow instance: upper bits and decode
        wr(1, BASE4 + 1, 32'hFFFF_FFFF);
        chk("w4_out", 32'(gout4), 32'h0000_000F);
        rd(1, "w4_rd_out", BASE4 + 1, 32'h0000_000F);
        wr(1, BASE4 + 9, 32'hFFFF_FFFF);
        chk("w4_unmapped_oe", 32'(goe4), 32'h0);
        rd(1, "w4_rd_unmapped", BASE4 + 9, 32'h0);
        rd(1, "w4_rd_status", BASE4 + 8, 32'h0);

        // Asynchronous reset mid-operation
        pins = '0;
        repeat (4) tick();
        wr(0, BASE + 1, 32'h3FF);
        wr(0, BASE + 2, 32'h3FF);
        wr(0, BASE + 6, 32'h001);
        pins[0] = 1'b1;
        repeat (4) tick();
        rd(0, "pre_rst_rdata", BASE + 1, 32'h3FF);
        chk("pre_rst_irq", 32'(irq), 32'h1);
        chk("pre_rst_out", 32'(gout), 32'h3FF);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out", 32'(gout), 32'h0);
        chk("async_rst_oe", 32'(goe), 32'h0);
        chk("async_rst_irq", 32'(irq), 32'h0);
        chk("async_rst_rdata", rdata, 32'h0);
        chk("async_rst_out4", 32'(gout4), 32'h0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
